// File: rtl/sr_reg_dump_if.sv
// Bus bundle for sr_reg_dump: control, CPU debug read port and the output word stream.
interface sr_reg_dump_if;
  logic        start;
  logic        abort;
  logic [4:0]  first_reg;
  logic [4:0]  last_reg;
  logic [4:0]  regAddr;
  logic [31:0] regData;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_addr;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    input  start, abort, first_reg, last_reg, regData, out_ready,
    output regAddr, out_valid, out_addr, out_data, out_last, busy, done, err
  );

  modport slave (
    output start, abort, first_reg, last_reg, regData, out_ready,
    input  regAddr, out_valid, out_addr, out_data, out_last, busy, done, err
  );
endinterface

// File: rtl/sr_reg_dump.sv
// Walks a range of CPU registers over the debug read port and streams each
// captured value out as a valid/ready word, one word per FETCH/SEND pair.
module sr_reg_dump #(
  parameter bit WRAP_EN = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  sr_reg_dump_if.master bus
);

  typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;

  state_t      state, stateNext;
  logic [4:0]  cur, curNext;
  logic [4:0]  lastIdx, lastNext;
  logic [4:0]  outAddr;
  logic [31:0] outData;
  logic        outLast;
  logic        doneQ, doneNext;
  logic        errQ, errNext;
  logic        capture;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= stateNext;
  end

  // abort outranks the out_ready handshake, so an aborted word is never counted
  always_comb begin
    stateNext = state;
    curNext   = cur;
    lastNext  = lastIdx;
    capture   = 1'b0;
    doneNext  = 1'b0;
    errNext   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (!WRAP_EN && (bus.first_reg > bus.last_reg)) begin
            errNext = 1'b1;
          end else begin
            stateNext = FETCH;
            curNext   = bus.first_reg;
            lastNext  = bus.last_reg;
          end
        end
      end
      FETCH: begin
        if (bus.abort) begin
          stateNext = IDLE;
        end else begin
          capture   = 1'b1;
          stateNext = SEND;
        end
      end
      SEND: begin
        if (bus.abort) begin
          stateNext = IDLE;
        end else if (bus.out_ready) begin
          if (outLast) begin
            stateNext = IDLE;
            doneNext  = 1'b1;
          end else begin
            stateNext = FETCH;
            curNext   = cur + 5'd1;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur     <= '0;
      lastIdx <= '0;
      outAddr <= '0;
      outData <= '0;
      outLast <= 1'b0;
      doneQ   <= 1'b0;
      errQ    <= 1'b0;
    end else begin
      cur     <= curNext;
      lastIdx <= lastNext;
      doneQ   <= doneNext;
      errQ    <= errNext;
      if (capture) begin
        outData <= bus.regData;
        outAddr <= cur;
        outLast <= (cur == lastIdx);
      end
    end
  end

  assign bus.regAddr   = (state == IDLE) ? '0 : cur;
  assign bus.out_valid = (state == SEND);
  assign bus.out_addr  = outAddr;
  assign bus.out_data  = outData;
  assign bus.out_last  = outLast;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = doneQ;
  assign bus.err       = errQ;

endmodule

// File: tb/tb_sr_reg_dump.sv
// Directed bench for sr_reg_dump: a wrapping instance (A) and a non-wrapping one (B)
// share clock and reset; a small register-file model answers the debug reads.
module tb_sr_reg_dump;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sr_reg_dump_if ia();
  sr_reg_dump_if ib();

  sr_reg_dump #(.WRAP_EN(1'b1)) dutA (.clk(clk), .rst(rst), .bus(ia.master));
  sr_reg_dump #(.WRAP_EN(1'b0)) dutB (.clk(clk), .rst(rst), .bus(ib.master));

  localparam logic [31:0] PC_VALUE = 32'hC0DE_0100;

  function automatic logic [31:0] regModel(input logic [4:0] a);
    return (a == 5'd0) ? PC_VALUE : {8'h80, 3'b000, a, 11'h000, a};
  endfunction

  assign ia.regData = regModel(ia.regAddr);
  assign ib.regData = regModel(ib.regAddr);

  int unsigned nCmp  = 0;
  int unsigned nFail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkAZero(input string tag);
    check({tag, "_regAddr"},   32'(ia.regAddr),   0);
    check({tag, "_out_valid"}, 32'(ia.out_valid), 0);
    check({tag, "_out_addr"},  32'(ia.out_addr),  0);
    check({tag, "_out_data"},  ia.out_data,       0);
    check({tag, "_out_last"},  32'(ia.out_last),  0);
    check({tag, "_busy"},      32'(ia.busy),      0);
    check({tag, "_done"},      32'(ia.done),      0);
    check({tag, "_err"},       32'(ia.err),       0);
  endtask

  // Full dump on A with out_ready held high; checks every cycle of the t+1..t+2N+2 window.
  task automatic runDump(input logic [4:0] f, input logic [4:0] l,
                         input int unsigned words, input logic withAbort);
    logic [4:0] a;
    ia.first_reg = f;
    ia.last_reg  = l;
    ia.start     = 1'b1;
    ia.abort     = withAbort;
    ia.out_ready = 1'b1;
    tick();
    ia.start = 1'b0;
    ia.abort = 1'b0;
    check("dump_t1_busy",    32'(ia.busy),      1);
    check("dump_t1_regAddr", 32'(ia.regAddr),   32'(f));
    check("dump_t1_valid",   32'(ia.out_valid), 0);
    check("dump_t1_err",     32'(ia.err),       0);
    for (int unsigned i = 0; i < words; i++) begin
      a = f + 5'(i);
      tick();
      check("word_valid", 32'(ia.out_valid), 1);
      check("word_addr",  32'(ia.out_addr),  32'(a));
      check("word_data",  ia.out_data,       regModel(a));
      check("word_last",  32'(ia.out_last),  32'(i == words - 1));
      check("word_done",  32'(ia.done),      0);
      tick();
      if (i != words - 1) begin
        check("gap_valid",   32'(ia.out_valid), 0);
        check("gap_regAddr", 32'(ia.regAddr),   32'(5'(a + 5'd1)));
      end else begin
        check("end_done",  32'(ia.done),      1);
        check("end_busy",  32'(ia.busy),      0);
        check("end_valid", 32'(ia.out_valid), 0);
      end
    end
    tick();
    check("done_pulse_width", 32'(ia.done), 0);
  endtask

  typedef struct {
    logic [4:0]  first;
    logic [4:0]  last;
    int unsigned words;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{5'd1,  5'd3,  3};
    vecs[1] = '{5'd30, 5'd1,  4};
    vecs[2] = '{5'd0,  5'd0,  1};
    vecs[3] = '{5'd31, 5'd0,  2};
    vecs[4] = '{5'd29, 5'd29, 1};

    ia.start = 1'b0; ia.abort = 1'b0; ia.first_reg = '0; ia.last_reg = '0; ia.out_ready = 1'b0;
    ib.start = 1'b0; ib.abort = 1'b0; ib.first_reg = '0; ib.last_reg = '0; ib.out_ready = 1'b0;

    #12;
    checkAZero("reset");
    check("reset_B_busy", 32'(ib.busy), 0);
    rst = 1'b1;
    tick();

    for (int unsigned v = 0; v < 5; v++)
      runDump(vecs[v].first, vecs[v].last, vecs[v].words, 1'b0);

    // Abort during the second word of 0..31, with out_ready also high
    ia.first_reg = 5'd0; ia.last_reg = 5'd31; ia.start = 1'b1; ia.out_ready = 1'b1;
    tick();
    ia.start = 1'b0;
    tick();
    check("abort_w0_addr", 32'(ia.out_addr), 0);
    check("abort_w0_data", ia.out_data, PC_VALUE);
    tick();
    tick();
    check("abort_w1_valid", 32'(ia.out_valid), 1);
    check("abort_w1_addr",  32'(ia.out_addr),  1);
    ia.abort = 1'b1;
    tick();
    ia.abort = 1'b0;
    check("abort_valid", 32'(ia.out_valid), 0);
    check("abort_busy",  32'(ia.busy),      0);
    check("abort_done",  32'(ia.done),      0);
    check("abort_err",   32'(ia.err),       0);
    tick();
    check("abort_done_later", 32'(ia.done), 0);
    check("abort_idle_later", 32'(ia.busy), 0);
    // start and abort together in IDLE: start wins
    runDump(5'd7, 5'd7, 1, 1'b1);

    // Stall for 5 cycles in SEND; a start while busy must be ignored
    ia.first_reg = 5'd4; ia.last_reg = 5'd5; ia.start = 1'b1; ia.out_ready = 1'b0;
    tick();
    ia.start = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      check("stall_valid",   32'(ia.out_valid), 1);
      check("stall_addr",    32'(ia.out_addr),  4);
      check("stall_data",    ia.out_data,       regModel(5'd4));
      check("stall_regAddr", 32'(ia.regAddr),   4);
      if (k == 2) begin
        ia.first_reg = 5'd20; ia.last_reg = 5'd20;
      end
      ia.start = (k == 2);
      tick();
    end
    ia.start = 1'b0;
    check("stall_end_addr", 32'(ia.out_addr), 4);
    check("stall_end_last", 32'(ia.out_last), 0);
    check("busy_start_err", 32'(ia.err),      0);
    ia.out_ready = 1'b1;
    tick();
    ia.out_ready = 1'b0;
    check("accept_valid",   32'(ia.out_valid), 0);
    check("accept_regAddr", 32'(ia.regAddr),   5);
    tick();
    check("next_addr",  32'(ia.out_addr),  5);
    check("next_data",  ia.out_data,       regModel(5'd5));
    check("next_last",  32'(ia.out_last),  1);
    check("next_valid", 32'(ia.out_valid), 1);
    ia.out_ready = 1'b1;
    tick();
    check("stall_done", 32'(ia.done), 1);
    check("stall_busy", 32'(ia.busy), 0);
    tick();
    check("stall_done_pulse", 32'(ia.done), 0);

    // Non-wrapping instance rejects a descending range
    ib.first_reg = 5'd5; ib.last_reg = 5'd2; ib.start = 1'b1; ib.out_ready = 1'b1;
    tick();
    ib.start = 1'b0;
    check("rej_err",   32'(ib.err),       1);
    check("rej_busy",  32'(ib.busy),      0);
    check("rej_valid", 32'(ib.out_valid), 0);
    tick();
    check("rej_err_pulse", 32'(ib.err),       0);
    check("rej_busy2",     32'(ib.busy),      0);
    check("rej_valid2",    32'(ib.out_valid), 0);
    ib.first_reg = 5'd2; ib.last_reg = 5'd5; ib.start = 1'b1;
    tick();
    ib.start = 1'b0;
    check("B_accept_busy",    32'(ib.busy),    1);
    check("B_accept_err",     32'(ib.err),     0);
    check("B_accept_regAddr", 32'(ib.regAddr), 2);
    ib.abort = 1'b1;
    tick();
    ib.abort = 1'b0;
    check("B_abort_busy", 32'(ib.busy), 0);

    // Asynchronous reset between edges mid-dump
    ia.first_reg = 5'd10; ia.last_reg = 5'd12; ia.start = 1'b1; ia.out_ready = 1'b0;
    tick();
    ia.start = 1'b0;
    tick();
    check("pre_rst_valid", 32'(ia.out_valid), 1);
    check("pre_rst_addr",  32'(ia.out_addr),  10);
    #3;
    rst = 1'b0;
    #1;
    checkAZero("async_rst");
    #2;
    rst = 1'b1;
    tick();
    check("post_rst_busy",  32'(ia.busy),      0);
    check("post_rst_valid", 32'(ia.out_valid), 0);
    runDump(5'd2, 5'd3, 2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
